timer_apb_arb: RTL and testbench
================================

TIMER_APB_ARB -- requirements
Module: timer_apb_arb

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, meaning extra ACCESS cycles inserted before completion (range 0..7).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports m0_psel, m0_penable, m0_pwrite  input  1 each  APB master 0 (CPU) control.
REQ-005 SHALL have ports m0_paddr  input  12, m0_pwdata  input  32, m0_pstrb  input  4  master 0 address, write data, byte strobes.
REQ-006 SHALL have ports m0_prdata  output  32, m0_pready  output  1, m0_pslverr  output  1  master 0 response.
REQ-007 SHALL have ports m1_* identical to REQ-004..006  APB master 1 (debugger).
REQ-008 SHALL have ports wr_en, rd_en  output  1 each  one-cycle access strobes to the timer register set.
REQ-009 SHALL have ports addr  output  12, wdata  output  32, pstrb  output  4  muxed from the granted master.
REQ-010 SHALL have ports rdata  input  32, pslverr  input  1  combinational response from the register set, valid in the strobe cycle.
REQ-011 SHALL have port gnt  output  2  one-hot current owner (01=m0, 10=m1, 00=none).

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, with a 3-bit wait counter.
REQ-013 IDLE: if any mX_psel=1, SHALL latch the winner into gnt, load wait counter with WAIT_STATES, and move to ACCESS next cycle; otherwise stay in IDLE with gnt=00.
REQ-014 Arbitration SHALL be round-robin: with both psel high, the master not served last wins; if only one requests, it wins regardless of history.
REQ-015 The last-served pointer SHALL update only on a completed transfer; reset value points at m1, so m0 wins the first contention.
REQ-016 ACCESS with counter>0 and owner psel&penable=1 SHALL decrement the counter; all strobes and pready stay 0.
REQ-017 ACCESS with counter==0 and owner psel&penable=1 SHALL be the completion cycle: wr_en=pwrite, rd_en=~pwrite, owner pready=1, owner prdata=rdata, owner pslverr=pslverr; next state IDLE.
REQ-018 addr/wdata/pstrb SHALL be the owner's inputs while gnt!=00 and zero otherwise.
REQ-019 The non-owner's pready, pslverr and prdata SHALL be 0 in every cycle; its request SHALL wait, held, until arbitrated.
REQ-020 Owner psel dropping in ACCESS before completion SHALL abort: no strobe, no pointer update, return to IDLE.
REQ-021 Owner penable=0 in ACCESS SHALL stall (counter held, no strobe).
REQ-022 Minimum transfer SHALL be 2 cycles (IDLE grant + completion) at WAIT_STATES=0, i.e. WAIT_STATES+2 in general; back-to-back transfers have no extra bubble beyond IDLE.
REQ-023 wr_en and rd_en SHALL never be high together nor for more than one consecutive cycle per transfer.

Reset
REQ-024 On rst_n=0, SHALL asynchronously force IDLE, gnt=00, wait counter=0, pointer=m1, and all strobes, pready, pslverr, prdata, addr, wdata, pstrb to 0.
REQ-025 Reset mid-ACCESS SHALL drop the transfer silently; no strobe is issued after rst_n rises until a new request is granted.

Structure
REQ-026 State encoding and timer register offsets (TCR 0x00 .. THCSR 0x1C) SHALL live in shared package timer_pkg.
REQ-027 The 2-way round-robin decision SHALL be sub-module rr_arb2 (inputs req[1:0], last; output one-hot grant), purely combinational.

Verification
REQ-028 WAIT_STATES=0, m0 writes 0x0000_0103 to 0x000 -> wr_en high exactly in cycle 2, addr=0x000, m0_pready=1 same cycle, gnt=01.
REQ-029 m0 and m1 raise psel in the same cycle, both reading 0x00C, then re-requesting -> order m0, m1, m0, m1; each sees prdata=0xFFFF_FFFF; loser's pready stays 0 while waiting.
REQ-030 WAIT_STATES=3, m1 reads 0x004 -> rd_en and m1_pready asserted in cycle 5 only, counter 3,2,1,0 observed.
REQ-031 m0 writes 0x0000_0900 to 0x000 while register set returns pslverr=1 -> m0_pslverr=1 with m0_pready in the strobe cycle, pointer advances.
REQ-032 WAIT_STATES=2, m0 deasserts psel after one ACCESS cycle -> no wr_en/rd_en, FSM back to IDLE, next contention still favours m0.
REQ-033 rst_n pulsed low during ACCESS of m1 -> all outputs 0 immediately, no strobe after release, gnt=00.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer block: arbiter FSM state encoding,
// owner codes and the timer register map offsets.
package timer_pkg;

    localparam int unsigned WAIT_W = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_e;

    // One-hot owner codes as seen on gnt
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Timer register set offsets
    localparam logic [11:0] TCR   = 12'h000;
    localparam logic [11:0] TSR   = 12'h004;
    localparam logic [11:0] TCNT  = 12'h008;
    localparam logic [11:0] TCMP  = 12'h00C;
    localparam logic [11:0] TPRE  = 12'h010;
    localparam logic [11:0] TIER  = 12'h014;
    localparam logic [11:0] TISR  = 12'h018;
    localparam logic [11:0] THCSR = 12'h01C;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin decision. last=1 means master 1 was served
// most recently, so master 0 takes a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // Lone requester always wins; ties go to whoever was not served last
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/timer_apb_arb.sv
// Two-master APB arbiter in front of the timer register set.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no owner; any psel is arbitrated and granted next cycle
//   ST_ACCESS | owner fixed in gnt; wait counter runs, completes at zero
//
// Completion-cycle strobes and responses are combinational from the
// registered owner so the register set sees them in the same cycle the
// master gets pready.
module timer_apb_arb
    import timer_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_psel,
    input  logic        m0_penable,
    input  logic        m0_pwrite,
    input  logic [11:0] m0_paddr,
    input  logic [31:0] m0_pwdata,
    input  logic [3:0]  m0_pstrb,
    output logic [31:0] m0_prdata,
    output logic        m0_pready,
    output logic        m0_pslverr,
    input  logic        m1_psel,
    input  logic        m1_penable,
    input  logic        m1_pwrite,
    input  logic [11:0] m1_paddr,
    input  logic [31:0] m1_pwdata,
    input  logic [3:0]  m1_pstrb,
    output logic [31:0] m1_prdata,
    output logic        m1_pready,
    output logic        m1_pslverr,
    output logic        wr_en,
    output logic        rd_en,
    output logic [11:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  pstrb,
    input  logic [31:0] rdata,
    input  logic        pslverr,
    output logic [1:0]  gnt
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

    arb_state_e        state_q;
    logic [1:0]        gnt_q;
    logic [WAIT_W-1:0] wait_q;
    logic              last_q;

    logic [1:0] req;
    logic [1:0] rr_grant;
    logic       own_sel;
    logic       own_en;
    logic       own_write;
    logic       xfer_beat;
    logic       xfer_done;

    assign req = {m1_psel, m0_psel};

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (last_q),
        .grant (rr_grant)
    );

    // Route the owner's APB request onto the register-set side
    always_comb begin
        own_sel   = 1'b0;
        own_en    = 1'b0;
        own_write = 1'b0;
        addr      = '0;
        wdata     = '0;
        pstrb     = '0;
        if (gnt_q[0]) begin
            own_sel   = m0_psel;
            own_en    = m0_penable;
            own_write = m0_pwrite;
            addr      = m0_paddr;
            wdata     = m0_pwdata;
            pstrb     = m0_pstrb;
        end else if (gnt_q[1]) begin
            own_sel   = m1_psel;
            own_en    = m1_penable;
            own_write = m1_pwrite;
            addr      = m1_paddr;
            wdata     = m1_pwdata;
            pstrb     = m1_pstrb;
        end
    end

    assign xfer_beat = (state_q == ST_ACCESS) && own_sel && own_en;
    assign xfer_done = xfer_beat && (wait_q == '0);

    assign gnt        = gnt_q;
    assign wr_en      = xfer_done & own_write;
    assign rd_en      = xfer_done & ~own_write;
    assign m0_pready  = xfer_done & gnt_q[0];
    assign m1_pready  = xfer_done & gnt_q[1];
    assign m0_pslverr = xfer_done & gnt_q[0] & pslverr;
    assign m1_pslverr = xfer_done & gnt_q[1] & pslverr;
    assign m0_prdata  = (xfer_done && gnt_q[0]) ? rdata : '0;
    assign m1_prdata  = (xfer_done && gnt_q[1]) ? rdata : '0;

    // Grant/wait/abort sequencing; the served pointer moves only on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_NONE;
            wait_q  <= '0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_q   <= rr_grant;
                        wait_q  <= WAIT_INIT;
                        state_q <= ST_ACCESS;
                    end else begin
                        gnt_q <= GNT_NONE;
                    end
                end
                ST_ACCESS: begin
                    if (!own_sel) begin
                        gnt_q   <= GNT_NONE;
                        state_q <= ST_IDLE;
                    end else if (own_en) begin
                        if (wait_q != '0) begin
                            wait_q <= wait_q - 1'b1;
                        end else begin
                            last_q  <= gnt_q[1];
                            gnt_q   <= GNT_NONE;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    gnt_q   <= GNT_NONE;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_apb_arb.sv
// Bench for timer_apb_arb: three instances (WAIT_STATES 0, 2, 3) share a
// clock and reset; a transaction-level model predicts every output each cycle.
module tb_timer_apb_arb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0][1:0]       psel, pen, pwr;
    logic [2:0][1:0][11:0] paddr;
    logic [2:0][1:0][31:0] pwdata;
    logic [2:0][1:0][3:0]  pstrb;
    logic [2:0][1:0][31:0] prdata;
    logic [2:0][1:0]       pready, pslv;
    logic [2:0]            wr_o, rd_o, err_in;
    logic [2:0][11:0]      addr_o;
    logic [2:0][31:0]      wdata_o, rdata_in;
    logic [2:0][3:0]       pstrb_o;
    logic [2:0][1:0]       gnt_o;

    int checks = 0;
    int failures = 0;

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
    endfunction

    // Register-set stub: TCMP reads all ones, others echo the offset
    function automatic logic [31:0] rd_stub(input logic [11:0] a);
        return (a == 12'h00C) ? 32'hFFFF_FFFF : {20'hA5A50, a};
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) rdata_in[i] = rd_stub(addr_o[i]);
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        timer_apb_arb #(.WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
            .clk(clk), .rst_n(rst_n),
            .m0_psel(psel[g][0]), .m0_penable(pen[g][0]), .m0_pwrite(pwr[g][0]),
            .m0_paddr(paddr[g][0]), .m0_pwdata(pwdata[g][0]), .m0_pstrb(pstrb[g][0]),
            .m0_prdata(prdata[g][0]), .m0_pready(pready[g][0]), .m0_pslverr(pslv[g][0]),
            .m1_psel(psel[g][1]), .m1_penable(pen[g][1]), .m1_pwrite(pwr[g][1]),
            .m1_paddr(paddr[g][1]), .m1_pwdata(pwdata[g][1]), .m1_pstrb(pstrb[g][1]),
            .m1_prdata(prdata[g][1]), .m1_pready(pready[g][1]), .m1_pslverr(pslv[g][1]),
            .wr_en(wr_o[g]), .rd_en(rd_o[g]), .addr(addr_o[g]), .wdata(wdata_o[g]),
            .pstrb(pstrb_o[g]), .rdata(rdata_in[g]), .pslverr(err_in[g]), .gnt(gnt_o[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: owner (-1 none), ACCESS beats still to wait, last served master
    int mo[3], mc[3], ml[3];
    int own;
    logic m_done;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                mo[i] = -1; mc[i] = 0; ml[i] = 1;
            end
            own = (mo[i] < 0) ? 0 : mo[i];
            m_done = rst_n && (mo[i] >= 0) && psel[i][own] && pen[i][own] && (mc[i] == 0);
            check("M_gnt", 32'(gnt_o[i]), (mo[i] < 0) ? 32'd0 : ((mo[i] == 0) ? 32'd1 : 32'd2));
            check("M_addr", 32'(addr_o[i]), (mo[i] < 0) ? 32'd0 : 32'(paddr[i][own]));
            check("M_wdata", wdata_o[i], (mo[i] < 0) ? 32'd0 : pwdata[i][own]);
            check("M_pstrb", 32'(pstrb_o[i]), (mo[i] < 0) ? 32'd0 : 32'(pstrb[i][own]));
            check("M_wr_en", 32'(wr_o[i]), 32'(m_done && pwr[i][own]));
            check("M_rd_en", 32'(rd_o[i]), 32'(m_done && !pwr[i][own]));
            for (int m = 0; m < 2; m++) begin
                check("M_pready", 32'(pready[i][m]), 32'(m_done && own == m));
                check("M_prdata", prdata[i][m], (m_done && own == m) ? rd_stub(paddr[i][m]) : 32'd0);
                check("M_pslverr", 32'(pslv[i][m]), 32'(m_done && own == m && err_in[i]));
            end
            if (rst_n) begin
                if (mo[i] < 0) begin
                    if (psel[i] != 2'b00) begin
                        if (psel[i] == 2'b11) mo[i] = (ml[i] == 0) ? 1 : 0;
                        else mo[i] = psel[i][0] ? 0 : 1;
                        mc[i] = ws_of(i);
                    end
                end else if (!psel[i][own]) begin
                    mo[i] = -1;
                end else if (pen[i][own]) begin
                    if (mc[i] == 0) begin ml[i] = own; mo[i] = -1; end
                    else mc[i] = mc[i] - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic setup(input int k, input int m, input logic [11:0] a, input logic w,
                         input logic [31:0] d);
        psel[k][m] = 1'b1; pen[k][m] = 1'b0; pwr[k][m] = w;
        paddr[k][m] = a; pwdata[k][m] = d; pstrb[k][m] = 4'hF;
    endtask

    task automatic idle_m(input int k, input int m);
        psel[k][m] = 1'b0; pen[k][m] = 1'b0;
    endtask

    // Both masters issue n0/n1 transfers as well-behaved APB masters;
    // completion order is compared against exp_bits (bit j = master of j-th)
    task automatic contend(input int k, input int n0, input int n1, input logic [11:0] a,
                           input logic w, input logic [3:0] exp_bits, input int n_exp);
        int rem[2]; int ph[2]; logic dn[2]; int got[$]; int cyc;
        rem[0] = n0; rem[1] = n1;
        for (int m = 0; m < 2; m++) begin
            if (rem[m] > 0) begin setup(k, m, a, w, 32'hC0DE_0000 + 32'(m)); ph[m] = 1; end
            else ph[m] = 0;
        end
        cyc = 0;
        while ((rem[0] + rem[1]) > 0 && cyc < 100) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                dn[m] = pready[k][m];
                if (dn[m]) begin
                    got.push_back(m);
                    check("C_prdata", prdata[k][m], rd_stub(a));
                    check("C_loser_pready", 32'(pready[k][1-m]), 32'd0);
                end
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                if (ph[m] == 2 && dn[m]) begin
                    rem[m]--;
                    if (rem[m] > 0) begin ph[m] = 1; pen[k][m] = 1'b0; end
                    else begin ph[m] = 0; idle_m(k, m); end
                end else if (ph[m] == 1) begin
                    ph[m] = 2; pen[k][m] = 1'b1;
                end
            end
            cyc++;
        end
        checks++;
        if ((rem[0] + rem[1]) != 0) begin
            failures++;
            $display("FAIL C_timeout actual=%0d required=0 transfers outstanding", rem[0] + rem[1]);
            idle_m(k, 0); idle_m(k, 1);
        end
        for (int j = 0; j < n_exp; j++)
            check("C_order", (got.size() > j) ? 32'(got[j]) : 32'd99, 32'(exp_bits[j]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        psel = '0; pen = '0; pwr = '0; paddr = '0; pwdata = '0; pstrb = '0; err_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("R_gnt", 32'(gnt_o), 32'd0);
        check("R_strobes", 32'({wr_o, rd_o}), 32'd0);
        check("R_addr", 32'(addr_o[2]), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Round-robin: both read TCMP twice, expect m0,m1,m0,m1
        contend(0, 2, 2, 12'h00C, 1'b0, 4'b1010, 4);

        // Single zero-wait write of TCR
        tick();
        setup(0, 0, 12'h000, 1'b1, 32'h0000_0103);
        @(negedge clk);
        check("A_c1_gnt", 32'(gnt_o[0]), 32'd0);
        check("A_c1_wr", 32'(wr_o[0]), 32'd0);
        tick(); pen[0][0] = 1'b1;
        @(negedge clk);
        check("A_c2_wr", 32'(wr_o[0]), 32'd1);
        check("A_c2_addr", 32'(addr_o[0]), 32'h000);
        check("A_c2_wdata", wdata_o[0], 32'h0000_0103);
        check("A_c2_pready", 32'(pready[0][0]), 32'd1);
        check("A_c2_gnt", 32'(gnt_o[0]), 32'd1);
        tick(); idle_m(0, 0);
        @(negedge clk);
        check("A_c3_wr", 32'(wr_o[0]), 32'd0);
        check("A_c3_gnt", 32'(gnt_o[0]), 32'd0);

        // Slave error on write; pointer then favours m1
        tick();
        err_in[0] = 1'b1;
        setup(0, 0, 12'h000, 1'b1, 32'h0000_0900);
        tick(); pen[0][0] = 1'b1;
        @(negedge clk);
        check("D_pslverr", 32'(pslv[0][0]), 32'd1);
        check("D_pready", 32'(pready[0][0]), 32'd1);
        tick(); idle_m(0, 0); err_in[0] = 1'b0;
        contend(0, 1, 1, 12'h004, 1'b0, 4'b0001, 2);

        // WAIT_STATES=3 read by m1: counter 3,2,1,0 then completion in cycle 5
        tick();
        setup(2, 1, 12'h004, 1'b0, 32'd0);
        @(negedge clk);
        check("W_c1_rd", 32'(rd_o[2]), 32'd0);
        tick(); pen[2][1] = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            check("W_cnt", 32'(g_dut[2].u_dut.wait_q), 32'(5 - c));
            check("W_rd", 32'(rd_o[2]), (c == 5) ? 32'd1 : 32'd0);
            check("W_pready", 32'(pready[2][1]), (c == 5) ? 32'd1 : 32'd0);
            tick();
        end
        idle_m(2, 1);

        // WAIT_STATES=2 abort by m0 after one ACCESS beat
        tick();
        setup(1, 0, 12'h008, 1'b1, 32'h1234_5678);
        tick(); pen[1][0] = 1'b1;
        @(negedge clk);
        check("E_beat_gnt", 32'(gnt_o[1]), 32'd1);
        tick(); idle_m(1, 0);
        @(negedge clk);
        check("E_abort_wr", 32'({wr_o[1], rd_o[1]}), 32'd0);
        tick();
        @(negedge clk);
        check("E_idle_gnt", 32'(gnt_o[1]), 32'd0);
        tick();
        contend(1, 1, 1, 12'h010, 1'b1, 4'b0010, 2);

        // Reset during m1 ACCESS on the WAIT_STATES=3 instance
        tick();
        setup(2, 1, 12'h008, 1'b0, 32'd0);
        tick(); pen[2][1] = 1'b1;
        @(negedge clk);
        check("F_gnt_before", 32'(gnt_o[2]), 32'd2);
        @(posedge clk); #2;
        rst_n = 1'b0; idle_m(2, 1);
        #1;
        check("F_gnt_async", 32'(gnt_o[2]), 32'd0);
        check("F_addr_async", 32'(addr_o[2]), 32'd0);
        check("F_pready_async", 32'(pready[2]), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("F_no_strobe", 32'({wr_o[2], rd_o[2]}), 32'd0);
            check("F_gnt_idle", 32'(gnt_o[2]), 32'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
